dcache_bank_arbiter: RTL

Successor to the single-bank tag-compare/arbiter stage of the nonblocking L1 dcache. Arbitrates NR_PORTS requesters (port 0 = miss handler, ports 1..NR_PORTS-1 = cache controllers) onto NR_BANKS independent SRAM banks, so requests to different banks are granted in the same cycle. Performs registered tag compare and hit-way data select, and returns the result to the granted port one cycle later. Replaces fixed priority with round-robin per bank plus an anti-starvation override.

---
 rtl/std_cache_pkg.sv | 25 ++
 rtl/dcache_bank_arbiter_if.sv | 39 +++
 rtl/dcache_bank_rr_arb.sv | 72 +++++++
 rtl/dcache_bank_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/std_cache_pkg.sv
// Shared L1 dcache types and defaults for the banked tag-compare/arbiter stage.
package std_cache_pkg;

    localparam int unsigned NR_PORTS_DEF     = 5;
    localparam int unsigned NR_BANKS_DEF     = 2;
    localparam int unsigned SET_ASSOC_DEF    = 8;
    localparam int unsigned ADDR_WIDTH_DEF   = 12;
    localparam int unsigned BANK_LSB_DEF     = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 8;
    localparam int unsigned TAG_WIDTH        = 44;
    localparam int unsigned DATA_WIDTH       = 128;
    localparam int unsigned LINE_WIDTH       = 1 + TAG_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } line_t;

    // A single bank still needs a 1-bit index so selects stay legal.
    function automatic int unsigned bank_idx_width(input int unsigned nr_banks);
        return (nr_banks > 1) ? $clog2(nr_banks) : 1;
    endfunction

endpackage

// File: rtl/dcache_bank_arbiter_if.sv
// Requester and SRAM-bank bundle of the banked dcache arbiter.
interface dcache_bank_arbiter_if
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS   = NR_PORTS_DEF,
    parameter int unsigned NR_BANKS   = NR_BANKS_DEF,
    parameter int unsigned SET_ASSOC  = SET_ASSOC_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic [NR_PORTS-1:0]                      req_i;
    logic [NR_PORTS-1:0]                      we_i;
    logic [NR_PORTS*ADDR_WIDTH-1:0]           addr_i;
    logic [NR_PORTS*TAG_WIDTH-1:0]            tag_i;
    logic [NR_PORTS*LINE_WIDTH-1:0]           wdata_i;
    logic [NR_PORTS*SET_ASSOC-1:0]            wway_i;
    logic [NR_PORTS-1:0]                      gnt_o;
    logic [NR_PORTS-1:0]                      rvalid_o;
    logic [NR_PORTS-1:0]                      hit_o;
    logic [NR_PORTS*SET_ASSOC-1:0]            hit_way_o;
    logic [NR_PORTS*DATA_WIDTH-1:0]           rdata_o;
    logic                                     multi_hit_o;
    logic [NR_BANKS*SET_ASSOC-1:0]            bank_req_o;
    logic [NR_BANKS-1:0]                      bank_we_o;
    logic [NR_BANKS*ADDR_WIDTH-1:0]           bank_addr_o;
    logic [NR_BANKS*LINE_WIDTH-1:0]           bank_wdata_o;
    logic [NR_BANKS*SET_ASSOC*LINE_WIDTH-1:0] bank_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, tag_i, wdata_i, wway_i, bank_rdata_i,
        output gnt_o, rvalid_o, hit_o, hit_way_o, rdata_o, multi_hit_o,
               bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o
    );

    modport master (
        output req_i, we_i, addr_i, tag_i, wdata_i, wway_i, bank_rdata_i,
        input  gnt_o, rvalid_o, hit_o, hit_way_o, rdata_o, multi_hit_o,
               bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o
    );
endinterface

// File: rtl/dcache_bank_rr_arb.sv
// Single-bank arbiter: starved port first, then port 0, then round-robin over
// ports 1..NR_PORTS-1 starting at rr_ptr.
module dcache_bank_rr_arb #(
    parameter int unsigned NR_PORTS     = 5,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NR_PORTS-1:0] req_i,
    output logic [NR_PORTS-1:0] gnt_c
);
    localparam int unsigned PW = $clog2(NR_PORTS);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] starve_cnt_q [1:NR_PORTS-1];
    logic [CW-1:0] starve_cnt_d [1:NR_PORTS-1];
    logic          found;

    always_comb begin
        gnt_c    = '0;
        found    = 1'b0;
        rr_ptr_d = rr_ptr_q;
        for (int unsigned p = 1; p < NR_PORTS; p++) begin
            if (!found && req_i[p] && (starve_cnt_q[p] == CW'(STARVE_LIMIT))) begin
                gnt_c[p] = 1'b1;
                found    = 1'b1;
            end
        end
        if (!found && req_i[0]) begin
            gnt_c[0] = 1'b1;
            found    = 1'b1;
        end
        // Two ascending passes: ports at/after rr_ptr, then the wrapped ones.
        for (int unsigned p = 1; p < NR_PORTS; p++) begin
            if (!found && req_i[p] && (PW'(p) >= rr_ptr_q)) begin
                gnt_c[p] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int unsigned p = 1; p < NR_PORTS; p++) begin
            if (!found && req_i[p] && (PW'(p) < rr_ptr_q)) begin
                gnt_c[p] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int unsigned p = 1; p < NR_PORTS; p++) begin
            if (gnt_c[p]) begin
                rr_ptr_d = (p == NR_PORTS - 1) ? PW'(1) : PW'(p + 1);
            end
            if (req_i[p] && !gnt_c[p]) begin
                starve_cnt_d[p] = (starve_cnt_q[p] == CW'(STARVE_LIMIT)) ?
                                  starve_cnt_q[p] : starve_cnt_q[p] + CW'(1);
            end else begin
                starve_cnt_d[p] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= PW'(1);
            for (int unsigned p = 1; p < NR_PORTS; p++) begin
                starve_cnt_q[p] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dcache_bank_arbiter.sv
// Banked L1 dcache arbiter: per-bank port arbitration onto the SRAMs, then a
// registered-tag compare and hit-way select returned to the granted port.
module dcache_bank_arbiter
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS     = NR_PORTS_DEF,
    parameter int unsigned NR_BANKS     = NR_BANKS_DEF,
    parameter int unsigned SET_ASSOC    = SET_ASSOC_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned BANK_LSB     = BANK_LSB_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic                  clk_i,
    input logic                  rst_i,
    dcache_bank_arbiter_if.slave bus
);
    localparam int unsigned BW = bank_idx_width(NR_BANKS);

    logic [NR_PORTS-1:0][BW-1:0]        port_bank;
    logic [NR_BANKS-1:0][NR_PORTS-1:0]  bank_port_req;
    logic [NR_BANKS-1:0][NR_PORTS-1:0]  bank_gnt;
    logic [NR_BANKS-1:0][NR_PORTS-1:0]  rd_port_q, rd_port_d;
    logic [NR_BANKS-1:0][TAG_WIDTH-1:0] tag_q, tag_d;

    // Route each requesting port to the bank its address selects.
    always_comb begin
        port_bank     = '0;
        bank_port_req = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            port_bank[p] = (NR_BANKS > 1) ? bus.addr_i[p*ADDR_WIDTH + BANK_LSB +: BW] : '0;
            for (int unsigned b = 0; b < NR_BANKS; b++) begin
                bank_port_req[b][p] = bus.req_i[p] && (port_bank[p] == BW'(b));
            end
        end
    end

    for (genvar b = 0; b < NR_BANKS; b++) begin : g_bank
        dcache_bank_rr_arb #(
            .NR_PORTS    (NR_PORTS),
            .STARVE_LIMIT(STARVE_LIMIT)
        ) u_arb (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .req_i(bank_port_req[b]),
            .gnt_c(bank_gnt[b])
        );
    end

    // Drive the SRAM side from the one-hot grant and capture reads for compare.
    always_comb begin
        bus.gnt_o        = '0;
        bus.bank_req_o   = '0;
        bus.bank_we_o    = '0;
        bus.bank_addr_o  = '0;
        bus.bank_wdata_o = '0;
        rd_port_d        = '0;
        tag_d            = '0;
        for (int unsigned b = 0; b < NR_BANKS; b++) begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    bus.gnt_o[p]                               = 1'b1;
                    bus.bank_we_o[b]                           = bus.we_i[p];
                    bus.bank_req_o[b*SET_ASSOC +: SET_ASSOC]   = bus.we_i[p] ?
                        bus.wway_i[p*SET_ASSOC +: SET_ASSOC] : '1;
                    bus.bank_addr_o[b*ADDR_WIDTH +: ADDR_WIDTH] = bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                    bus.bank_wdata_o[b*LINE_WIDTH +: LINE_WIDTH] = bus.wdata_i[p*LINE_WIDTH +: LINE_WIDTH];
                    rd_port_d[b][p]                            = !bus.we_i[p];
                    tag_d[b]                                   = bus.tag_i[p*TAG_WIDTH +: TAG_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_port_q <= '0;
            tag_q     <= '0;
        end else begin
            rd_port_q <= rd_port_d;
            tag_q     <= tag_d;
        end
    end

    // Compare the returning ways against the latched tag; lowest hit wins.
    always_comb begin : resp
        line_t                 line;
        logic [SET_ASSOC-1:0]  hit_way;
        logic [SET_ASSOC-1:0]  hit_lo;
        logic [DATA_WIDTH-1:0] hit_data;
        line            = '0;
        hit_way         = '0;
        hit_lo          = '0;
        hit_data        = '0;
        bus.rvalid_o    = '0;
        bus.hit_o       = '0;
        bus.hit_way_o   = '0;
        bus.rdata_o     = '0;
        bus.multi_hit_o = 1'b0;
        for (int unsigned b = 0; b < NR_BANKS; b++) begin
            hit_way  = '0;
            hit_data = '0;
            for (int unsigned w = 0; w < SET_ASSOC; w++) begin
                line       = line_t'(bus.bank_rdata_i[(b*SET_ASSOC + w)*LINE_WIDTH +: LINE_WIDTH]);
                hit_way[w] = line.valid && (line.tag == tag_q[b]);
            end
            hit_lo = hit_way & (~hit_way + SET_ASSOC'(1));
            for (int unsigned w = 0; w < SET_ASSOC; w++) begin
                line = line_t'(bus.bank_rdata_i[(b*SET_ASSOC + w)*LINE_WIDTH +: LINE_WIDTH]);
                if (hit_lo[w]) begin
                    hit_data = line.data;
                end
            end
            if ((|rd_port_q[b]) && (|(hit_way & ~hit_lo))) begin
                bus.multi_hit_o = 1'b1;
            end
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                if (rd_port_q[b][p]) begin
                    bus.rvalid_o[p]                          = 1'b1;
                    bus.hit_o[p]                             = |hit_way;
                    bus.hit_way_o[p*SET_ASSOC +: SET_ASSOC]  = hit_lo;
                    bus.rdata_o[p*DATA_WIDTH +: DATA_WIDTH]  = hit_data;
                end
            end
        end
    end

endmodule
